image_double_full: RTL and testbench
====================================

# image_double_full

Nearest-neighbour 2x upsampler for the SIFT scale pyramid: the inverse of the 2x downsizing stage. On a start pulse it walks a source BRAM holding an OLD_WIDTH x OLD_HEIGHT image in row-major order. It writes each source pixel to the four corresponding pixels of a 2·OLD_WIDTH x 2·OLD_HEIGHT destination BRAM, then pulses done. It sits between a pyramid-level BRAM and the octave −1 BRAM feeding the Gaussian blur chain.

## Interface
- BIT_DEPTH, 8, pixel width
- OLD_WIDTH, 32, source width; power of two, ≥2
- OLD_HEIGHT, 32, source height; power of two, ≥2
- clk_in  input  1  system clock; all logic on rising edge
- rst_in  input  1  reset, asynchronous, active-low
- ext_read_addr  output  $clog2(OLD_WIDTH*OLD_HEIGHT)  source address, registered
- ext_read_addr_valid  output  1  one-cycle read strobe
- ext_pixel_in  input  BIT_DEPTH  source data; valid 2 cycles after the strobe
- ext_write_addr  output  $clog2(4*OLD_WIDTH*OLD_HEIGHT)  destination address, registered
- ext_write_valid  output  1  destination write enable
- ext_pixel_out  output  BIT_DEPTH  destination data
- start_in  input  1  one-cycle start pulse
- resize_done  output  1  one-cycle pulse after the final write
- busy_out  output  1  high from the cycle after start until resize_done
- src_x_used  output  $clog2(OLD_WIDTH)  x of the source pixel being written (debug)
- src_y_used  output  $clog2(OLD_HEIGHT)  y of the source pixel being written (debug)

## Operation
- States: IDLE, READ, WAIT1, WAIT2, WRITE.
- Transitions:
  - IDLE → READ on start_in.
  - READ → WAIT1 → WAIT2 → WRITE, one cycle each.
  - WRITE lasts 4 cycles, indexed by sub-counter q = 0..3. After q=3 it returns to READ, or goes to IDLE if the last source pixel is done.
- READ: drive ext_read_addr = x + y·OLD_WIDTH and assert ext_read_addr_valid for exactly one cycle.
- WAIT2: latch ext_pixel_in into an internal pixel register at the end of the cycle.
- WRITE: ext_write_valid is high and ext_pixel_out equals the latched pixel in all 4 cycles. Destination coordinates:
  - q=0: (2x, 2y)
  - q=1: (2x+1, 2y)
  - q=2: (2x, 2y+1)
  - q=3: (2x+1, 2y+1)
- Write address arithmetic: ext_write_addr = xd + yd·2·OLD_WIDTH. Compute it at the write-address width with no truncation.
- src_x_used and src_y_used hold the current (x, y) throughout WAIT2 and WRITE.
- Counter advance happens at the end of WRITE q=3:
  - If x < OLD_WIDTH−1: x increments.
  - Else x wraps to 0 and y increments.
  - At (OLD_WIDTH−1, OLD_HEIGHT−1): x and y clear to 0, state goes to IDLE, and resize_done pulses in the next cycle.
- start_in while not in IDLE is ignored; there is no restart.
- start_in in the same cycle resize_done is high is accepted; the next pass begins normally.
- Reset values: all outputs are 0 and state is IDLE.
- Reset asserted mid-pass: immediately aborts the pass.
  - No further reads or writes occur.
  - resize_done does not pulse.
  - The destination content is undefined.

## Timing
- Cycle 0: start_in is sampled high.
- Cycle 1: READ, ext_read_addr=0, ext_read_addr_valid=1.
- Cycle 3: source data is valid and is latched.
- Cycles 4–7: first four writes.
- Per source pixel k: READ occurs at cycle 1+7k; the writes occupy cycles 4+7k .. 7+7k.
- With N = OLD_WIDTH·OLD_HEIGHT:
  - The last write is in cycle 7N.
  - resize_done is high in cycle 7N+1.
  - busy_out falls in the same cycle.
- Throughput is 7 cycles per source pixel and 1.75 cycles per destination pixel.
- ext_read_addr_valid and ext_write_valid are never high in the same cycle.
- Source BRAM read latency is fixed at 2 cycles; no backpressure on either port.

## Test plan
- OLD_WIDTH=OLD_HEIGHT=4, source[a]=a; pulse start:
  - Destination (8x8) pixel at (xd, yd) equals (xd>>1) + (yd>>1)·4 for all 64 addresses.
  - Exactly 64 writes occur.
  - resize_done is high only in cycle 113.
- Same setup, check the first write burst: writes go to addresses 0, 1, 8, 9 with data 0 in cycles 4–7. The write to source pixel 3's q=3 lands at address 15.
- Row wrap: after source pixel (3,0), the next read is address 4 and its writes go to addresses 16, 17, 24, 25.
- start_in pulsed again in cycle 50 during a pass: no change to the address sequence, and done is still at cycle 113. A start in cycle 113 begins a second identical pass with its read in cycle 114.
- rst_in low in cycle 40:
  - All outputs are 0 within that cycle, including ext_write_valid.
  - No done pulse occurs.
  - After release, a new start produces a clean full pass from address 0.
- OLD_WIDTH=8, OLD_HEIGHT=2, all source pixels 8'hFF: 64 writes of 8'hFF with addresses covering 0–63 exactly once, and done in cycle 113.

Source files
------------

// File: rtl/image_double_full_if.sv
// Bus bundle for the 2x nearest-neighbour upsampler: source BRAM read port,
// destination BRAM write port, start/done control and debug coordinates.
interface image_double_full_if #(
    parameter int BIT_DEPTH  = 8,
    parameter int OLD_WIDTH  = 32,
    parameter int OLD_HEIGHT = 32
);
    localparam int RA_W = $clog2(OLD_WIDTH * OLD_HEIGHT);
    localparam int WA_W = $clog2(4 * OLD_WIDTH * OLD_HEIGHT);
    localparam int XW   = $clog2(OLD_WIDTH);
    localparam int YW   = $clog2(OLD_HEIGHT);

    logic [RA_W-1:0]      ext_read_addr;
    logic                 ext_read_addr_valid;
    logic [BIT_DEPTH-1:0] ext_pixel_in;
    logic [WA_W-1:0]      ext_write_addr;
    logic                 ext_write_valid;
    logic [BIT_DEPTH-1:0] ext_pixel_out;
    logic                 start_in;
    logic                 resize_done;
    logic                 busy_out;
    logic [XW-1:0]        src_x_used;
    logic [YW-1:0]        src_y_used;

    // The upsampler is the master: it drives both BRAM address buses.
    modport master (
        output ext_read_addr, ext_read_addr_valid,
        input  ext_pixel_in,
        output ext_write_addr, ext_write_valid, ext_pixel_out,
        input  start_in,
        output resize_done, busy_out, src_x_used, src_y_used
    );

    modport slave (
        input  ext_read_addr, ext_read_addr_valid,
        output ext_pixel_in,
        input  ext_write_addr, ext_write_valid, ext_pixel_out,
        output start_in,
        input  resize_done, busy_out, src_x_used, src_y_used
    );
endinterface

// File: rtl/image_double_full.sv
// Nearest-neighbour 2x upsampler: reads each source pixel once (2-cycle BRAM
// latency) and writes it to its 2x2 destination block; 7 cycles per pixel.
module image_double_full #(
    parameter int BIT_DEPTH  = 8,
    parameter int OLD_WIDTH  = 32,
    parameter int OLD_HEIGHT = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    image_double_full_if.master bus
);
    localparam int RA_W = $clog2(OLD_WIDTH * OLD_HEIGHT);
    localparam int WA_W = $clog2(4 * OLD_WIDTH * OLD_HEIGHT);
    localparam int XW   = $clog2(OLD_WIDTH);
    localparam int YW   = $clog2(OLD_HEIGHT);

    typedef enum logic [2:0] {IDLE, READ, WAIT1, WAIT2, WRITE} state_t;

    state_t               state, state_next;
    logic [XW-1:0]        x, x_next;
    logic [YW-1:0]        y, y_next;
    logic [1:0]           q, q_next;
    logic                 done_next;
    logic [BIT_DEPTH-1:0] pixel;

    logic [RA_W-1:0]      read_addr, read_addr_next;
    logic                 read_valid;
    logic [WA_W-1:0]      write_addr, write_addr_next;
    logic                 write_valid;
    logic                 done;
    logic                 busy;

    logic                 last_x, last_y;
    logic [WA_W-1:0]      xd, yd;

    assign last_x = (x == XW'(OLD_WIDTH - 1));
    assign last_y = (y == YW'(OLD_HEIGHT - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        q_next     = q;
        done_next  = 1'b0;
        case (state)
            IDLE:  if (bus.start_in) state_next = READ;
            READ:  state_next = WAIT1;
            WAIT1: state_next = WAIT2;
            WAIT2: begin
                state_next = WRITE;
                q_next     = 2'd0;
            end
            WRITE: begin
                if (q == 2'd3) begin
                    state_next = READ;
                    if (!last_x) begin
                        x_next = x + 1'b1;
                    end else begin
                        x_next = '0;
                        if (last_y) begin
                            y_next     = '0;
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            y_next = y + 1'b1;
                        end
                    end
                end else begin
                    q_next = q + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Addresses are computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        read_addr_next  = RA_W'(y_next) * RA_W'(OLD_WIDTH) + RA_W'(x_next);
        xd              = WA_W'({x_next, q_next[0]});
        yd              = WA_W'({y_next, q_next[1]});
        write_addr_next = yd * WA_W'(2 * OLD_WIDTH) + xd;
    end

    // NOTE: sequential state uses non-blocking assignments only; the pixel
    // register is reset too because it drives an output port directly.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            q           <= '0;
            pixel       <= '0;
            read_addr   <= '0;
            read_valid  <= 1'b0;
            write_addr  <= '0;
            write_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            x           <= x_next;
            y           <= y_next;
            q           <= q_next;
            read_addr   <= read_addr_next;
            read_valid  <= (state_next == READ);
            write_addr  <= write_addr_next;
            write_valid <= (state_next == WRITE);
            done        <= done_next;
            busy        <= (state_next != IDLE);
            if (state == WAIT2) pixel <= bus.ext_pixel_in;
        end
    end

    assign bus.ext_read_addr       = read_addr;
    assign bus.ext_read_addr_valid = read_valid;
    assign bus.ext_write_addr      = write_addr;
    assign bus.ext_write_valid     = write_valid;
    assign bus.ext_pixel_out       = pixel;
    assign bus.resize_done         = done;
    assign bus.busy_out            = busy;
    assign bus.src_x_used          = x;
    assign bus.src_y_used          = y;
endmodule

// File: tb/tb_image_double_full.sv
// Scoreboard bench for image_double_full: a 4x4 instance (ramp image) and an
// 8x2 instance (all 8'hFF), each fed by a 2-cycle-latency source BRAM model.
module tb_image_double_full;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    image_double_full_if #(.BIT_DEPTH(8), .OLD_WIDTH(4), .OLD_HEIGHT(4)) bus_a ();
    image_double_full_if #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(2)) bus_b ();

    image_double_full #(.BIT_DEPTH(8), .OLD_WIDTH(4), .OLD_HEIGHT(4)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .bus(bus_a));
    image_double_full #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(2)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .bus(bus_b));

    // Source BRAM models with two register stages of read latency
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] a_s1, a_s2, b_s1, b_s2;
    always @(posedge clk) begin
        a_s1 <= mem_a[bus_a.ext_read_addr];
        a_s2 <= a_s1;
        b_s1 <= mem_b[bus_b.ext_read_addr];
        b_s2 <= b_s1;
    end
    assign bus_a.ext_pixel_in = a_s2;
    assign bus_b.ext_pixel_in = b_s2;

    typedef struct {
        int id;
        int addr;
        int data;
        int cyc;
        int sx;
        int sy;
    } ev_t;

    ev_t rq[$];
    ev_t wq[$];
    ev_t dq[$];

    int dval [64];
    int dcnt [64];
    int wlog [64];
    int rlog [64];
    int wcount;
    int rcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] addr);
        total++;
        bad++;
        $display("FAIL unexpected_%s: got addr=%0d required no event (cycle %0d)", name, addr, cyc);
    endtask

    task automatic clear_log();
        for (int i = 0; i < 64; i++) begin
            dval[i] = -1;
            dcnt[i] = 0;
            wlog[i] = -1;
            rlog[i] = -1;
        end
        wcount = 0;
        rcount = 0;
    endtask

    // Expected event stream of one full pass starting with start sampled in cycle t0
    task automatic push_pass(input int id, input int t0, input int w, input int h, input bit ff);
        int n;
        n = w * h;
        for (int k = 0; k < n; k++) begin
            int x, y, src;
            x   = k % w;
            y   = k / w;
            src = ff ? 255 : (k % 256);
            rq.push_back('{id, k, 0, t0 + 1 + 7 * k, 0, 0});
            for (int q = 0; q < 4; q++) begin
                int xd, yd;
                xd = 2 * x + (q % 2);
                yd = 2 * y + (q / 2);
                wq.push_back('{id, yd * 2 * w + xd, src, t0 + 4 + 7 * k + q, x, y});
            end
        end
        dq.push_back('{id, 0, 0, t0 + 7 * n + 1, 0, 0});
    endtask

    task automatic observe(input int id, input logic rv, input logic [31:0] ra,
                           input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                           input logic done, input logic busy,
                           input logic [31:0] sx, input logic [31:0] sy);
        ev_t e;
        if (rv || wv) check("rd_wr_exclusive", {31'b0, rv & wv}, 32'd0);
        if (rv) begin
            if (rq.size() == 0) unexpected("read", ra);
            else begin
                e = rq.pop_front();
                check("rd_dut", id, e.id);
                check("rd_addr", ra, e.addr);
                check("rd_cycle", cyc, e.cyc);
                check("rd_busy", {31'b0, busy}, 32'd1);
            end
            if (rcount < 64) rlog[rcount] = int'(ra);
            rcount++;
        end
        if (wv) begin
            if (wq.size() == 0) unexpected("write", wa);
            else begin
                e = wq.pop_front();
                check("wr_dut", id, e.id);
                check("wr_addr", wa, e.addr);
                check("wr_data", wd, e.data);
                check("wr_cycle", cyc, e.cyc);
                check("wr_src_x", sx, e.sx);
                check("wr_src_y", sy, e.sy);
            end
            if (wa < 64) begin
                dval[wa] = int'(wd);
                dcnt[wa]++;
            end
            if (wcount < 64) wlog[wcount] = int'(wa);
            wcount++;
        end
        if (done) begin
            if (dq.size() == 0) unexpected("done", 0);
            else begin
                e = dq.pop_front();
                check("done_dut", id, e.id);
                check("done_cycle", cyc, e.cyc);
                check("done_busy_low", {31'b0, busy}, 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, bus_a.ext_read_addr_valid, 32'(bus_a.ext_read_addr),
                    bus_a.ext_write_valid, 32'(bus_a.ext_write_addr), 32'(bus_a.ext_pixel_out),
                    bus_a.resize_done, bus_a.busy_out,
                    32'(bus_a.src_x_used), 32'(bus_a.src_y_used));
            observe(1, bus_b.ext_read_addr_valid, 32'(bus_b.ext_read_addr),
                    bus_b.ext_write_valid, 32'(bus_b.ext_write_addr), 32'(bus_b.ext_pixel_out),
                    bus_b.resize_done, bus_b.busy_out,
                    32'(bus_b.src_x_used), 32'(bus_b.src_y_used));
        end
    end

    task automatic check_zero_a(input string tag);
        check({tag, "_rd_valid"}, 32'(bus_a.ext_read_addr_valid), 32'd0);
        check({tag, "_wr_valid"}, 32'(bus_a.ext_write_valid), 32'd0);
        check({tag, "_rd_addr"},  32'(bus_a.ext_read_addr), 32'd0);
        check({tag, "_wr_addr"},  32'(bus_a.ext_write_addr), 32'd0);
        check({tag, "_pix_out"},  32'(bus_a.ext_pixel_out), 32'd0);
        check({tag, "_done"},     32'(bus_a.resize_done), 32'd0);
        check({tag, "_busy"},     32'(bus_a.busy_out), 32'd0);
        check({tag, "_src_x"},    32'(bus_a.src_x_used), 32'd0);
        check({tag, "_src_y"},    32'(bus_a.src_y_used), 32'd0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int id, output int t0);
        @(posedge clk);
        #1;
        if (id == 0) bus_a.start_in = 1'b1;
        else         bus_b.start_in = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        bus_a.start_in = 1'b0;
        bus_b.start_in = 1'b0;
    endtask

    // Destination of the 4x4 ramp: pixel (xd, yd) holds its source index
    task automatic check_dest_a();
        check("wr_count", wcount, 32'd64);
        for (int yd = 0; yd < 8; yd++)
            for (int xd = 0; xd < 8; xd++) begin
                check("dest_val", dval[yd * 8 + xd], (xd >> 1) + (yd >> 1) * 4);
                check("dest_once", dcnt[yd * 8 + xd], 32'd1);
            end
    endtask

    int t0;
    int t1;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'hFF;
        end
        clear_log();
        rst_n          = 1'b0;
        bus_a.start_in = 1'b0;
        bus_b.start_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pass 1 with a stray start at cycle 50, then a back-to-back start on done
        clear_log();
        pulse_start(0, t0);
        push_pass(0, t0, 4, 4, 1'b0);
        wait_until(t0 + 50);
        bus_a.start_in = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start_in = 1'b0;
        wait_until(t0 + 113);
        check_dest_a();
        check("burst_w0", wlog[0], 32'd0);
        check("burst_w1", wlog[1], 32'd1);
        check("burst_w2", wlog[2], 32'd8);
        check("burst_w3", wlog[3], 32'd9);
        check("pix3_q3", wlog[15], 32'd15);
        check("wrap_read", rlog[4], 32'd4);
        check("wrap_w0", wlog[16], 32'd16);
        check("wrap_w1", wlog[17], 32'd17);
        check("wrap_w2", wlog[18], 32'd24);
        check("wrap_w3", wlog[19], 32'd25);
        clear_log();
        bus_a.start_in = 1'b1;
        t1 = cyc;
        push_pass(0, t1, 4, 4, 1'b0);
        @(posedge clk);
        #1;
        bus_a.start_in = 1'b0;
        wait_until(t1 + 116);
        check_dest_a();

        // Reset in the middle of a pass
        clear_log();
        pulse_start(0, t0);
        push_pass(0, t0, 4, 4, 1'b0);
        wait_until(t0 + 40);
        rst_n = 1'b0;
        rq.delete();
        wq.delete();
        dq.delete();
        @(negedge clk);
        check_zero_a("midpass_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        clear_log();
        pulse_start(0, t0);
        push_pass(0, t0, 4, 4, 1'b0);
        wait_until(t0 + 116);
        check_dest_a();

        // 8x2 all-white source
        clear_log();
        pulse_start(1, t0);
        push_pass(1, t0, 8, 2, 1'b1);
        wait_until(t0 + 116);
        check("b_wr_count", wcount, 32'd64);
        for (int a = 0; a < 64; a++) begin
            check("b_dest_once", dcnt[a], 32'd1);
            check("b_dest_val", dval[a], 32'd255);
        end

        check("reads_left", rq.size(), 32'd0);
        check("writes_left", wq.size(), 32'd0);
        check("dones_left", dq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
